// File: rtl/safe_pkg.sv
// safe_pkg: shared types and constants for the PIN safe front-end.
// Imported by the request interface, the arbiter and the controller.
package safe_pkg;

  localparam int PIN_W    = 16;
  localparam int NIBBLE_W = 4;
  localparam int NIBBLES  = 4;

  typedef enum logic [3:0] {
    IDLE,
    RSTSAFE,
    SEND0,
    SEND1,
    SEND2,
    SEND3,
    CHECK,
    HOLD,
    RELOCK,
    PENALTY,
    DEAD
  } ctrl_state_t;

  // Nibble k of a PIN, k=0 being the most significant.
  function automatic logic [NIBBLE_W-1:0] pin_nibble(
    input logic [PIN_W-1:0] pin,
    input logic [1:0]       k
  );
    logic [NIBBLE_W-1:0] n;
    unique case (k)
      2'd0: n = pin[15:12];
      2'd1: n = pin[11:8];
      2'd2: n = pin[7:4];
      2'd3: n = pin[3:0];
    endcase
    return n;
  endfunction

endpackage

// File: rtl/safe_seq_ctrl_if.sv
// safe_seq_ctrl_if: requester-side request/response bundle.
// master = requesters, slave = controller.
interface safe_seq_ctrl_if #(
  parameter int NREQ = 2
) ();
  import safe_pkg::*;

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid;
  logic [PIN_W*NREQ-1:0] req_pin;
  logic [NREQ-1:0]       req_ready;
  logic                  resp_valid;
  logic [IDW-1:0]        resp_id;
  logic                  resp_ok;

  modport master (
    output req_valid,
    output req_pin,
    input  req_ready,
    input  resp_valid,
    input  resp_id,
    input  resp_ok
  );

  modport slave (
    input  req_valid,
    input  req_pin,
    output req_ready,
    output resp_valid,
    output resp_id,
    output resp_ok
  );

endinterface

// File: rtl/safe_rr_arbiter.sv
// safe_rr_arbiter: round-robin pick among NREQ requesters.
// The search start pointer only moves when a grant is taken.
module safe_rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req_i,
  input  logic            advance_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  grant_idx_o,
  output logic            grant_vld_o
);

  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;

  function automatic int wrap_idx(input int base, input int off);
    return (base + off) % NREQ;
  endfunction

  // First active request at or after the pointer, wrapping.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!grant_vld_o && req_i[j] &&
            j == wrap_idx(int'(ptr_q), i)) begin
          grant_vld_o = 1'b1;
          grant_o[j]  = 1'b1;
          grant_idx_o = IDW'(j);
        end
      end
    end
  end

  // Next search starts just past the winner.
  always_comb begin
    ptr_d = ptr_q;
    if (int'(grant_idx_o) == NREQ - 1) ptr_d = '0;
    else ptr_d = IDW'(int'(grant_idx_o) + 1);
  end

  // Pointer register, moved only on a taken grant.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else if (advance_i && grant_vld_o) ptr_q <= ptr_d;
  end

endmodule

// File: rtl/safe_seq_ctrl.sv
// safe_seq_ctrl: arbitrated front-end that streams PINs into the safe,
// reports pass/fail, and applies penalty, lockout and relock policy.
module safe_seq_ctrl
  import safe_pkg::*;
#(
  parameter  int NREQ           = 2,
  parameter  int LOCKOUT_CYCLES = 16,
  parameter  int HOLD_CYCLES    = 8,
  parameter  int MAX_FAILS      = 3,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int FCW  = $clog2(MAX_FAILS + 1),
  localparam int MAXT = (LOCKOUT_CYCLES > HOLD_CYCLES) ?
                        LOCKOUT_CYCLES : HOLD_CYCLES,
  localparam int TW   = $clog2(MAXT + 1)
) (
  input  logic                clk,
  input  logic                reset,
  safe_seq_ctrl_if.slave      bus,
  output logic                safe_reset,
  output logic [NIBBLE_W-1:0] safe_din,
  output logic                safe_din_valid,
  input  logic                safe_unlocked,
  output logic                locked_out,
  output logic [FCW-1:0]      fail_count
);

  ctrl_state_t      state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [FCW-1:0]   fail_q, fail_d;
  logic [PIN_W-1:0] pin_q;
  logic [IDW-1:0]   id_q;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic             grant_vld;
  logic             idle;
  logic             accept;
  logic [PIN_W-1:0] sel_pin;

  safe_rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .clk        (clk),
    .reset      (reset),
    .req_i      (bus.req_valid),
    .advance_i  (accept),
    .grant_o    (grant),
    .grant_idx_o(grant_idx),
    .grant_vld_o(grant_vld)
  );

  assign idle          = (state_q == IDLE) && !reset;
  assign bus.req_ready = idle ? grant : '0;
  assign accept        = idle && grant_vld;
  assign fail_count    = reset ? '0 : fail_q;

  // PIN of the current arbitration winner.
  always_comb begin
    sel_pin = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) sel_pin = bus.req_pin[PIN_W*i +: PIN_W];
    end
  end

  // Sequencing, timers and failure bookkeeping.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    fail_d  = fail_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RSTSAFE;
      RSTSAFE: state_d = SEND0;
      SEND0:   state_d = SEND1;
      SEND1:   state_d = SEND2;
      SEND2:   state_d = SEND3;
      SEND3:   state_d = CHECK;
      CHECK: begin
        if (safe_unlocked) begin
          fail_d  = '0;
          state_d = HOLD;
          timer_d = TW'(HOLD_CYCLES - 1);
        end else begin
          if (fail_q != FCW'(MAX_FAILS)) fail_d = fail_q + 1'b1;
          if (fail_d == FCW'(MAX_FAILS)) begin
            state_d = DEAD;
          end else begin
            state_d = PENALTY;
            timer_d = TW'(LOCKOUT_CYCLES - 1);
          end
        end
      end
      HOLD: begin
        if (timer_q == '0) state_d = RELOCK;
        else timer_d = timer_q - 1'b1;
      end
      RELOCK:  state_d = IDLE;
      PENALTY: begin
        if (timer_q == '0) state_d = IDLE;
        else timer_d = timer_q - 1'b1;
      end
      DEAD:    state_d = DEAD;
      default: state_d = IDLE;
    endcase
  end

  // Safe-side drive and result pulse; everything quiet in reset.
  always_comb begin
    safe_reset     = reset;
    safe_din       = '0;
    safe_din_valid = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_id    = '0;
    bus.resp_ok    = 1'b0;
    locked_out     = 1'b0;
    if (!reset) begin
      unique case (state_q)
        RSTSAFE, RELOCK, PENALTY: safe_reset = 1'b1;
        SEND0: begin
          safe_din_valid = 1'b1;
          safe_din       = pin_nibble(pin_q, 2'd0);
        end
        SEND1: begin
          safe_din_valid = 1'b1;
          safe_din       = pin_nibble(pin_q, 2'd1);
        end
        SEND2: begin
          safe_din_valid = 1'b1;
          safe_din       = pin_nibble(pin_q, 2'd2);
        end
        SEND3: begin
          safe_din_valid = 1'b1;
          safe_din       = pin_nibble(pin_q, 2'd3);
        end
        CHECK: begin
          bus.resp_valid = 1'b1;
          bus.resp_id    = id_q;
          bus.resp_ok    = safe_unlocked;
        end
        DEAD: begin
          safe_reset = 1'b1;
          locked_out = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State, timer, fail count and latched request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      fail_q  <= '0;
      pin_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      fail_q  <= fail_d;
      if (accept) begin
        pin_q <= sel_pin;
        id_q  <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_safe_seq_ctrl.sv
// tb_safe_seq_ctrl: scenario tasks driving the controller against a
// small behavioural safe; responses are checked from a queue.
module tb_safe_seq_ctrl;
  import safe_pkg::*;

  localparam int NREQ = 2;
  localparam int LOCK = 16;
  localparam int HOLD = 8;
  localparam int MAXF = 3;
  localparam int IDW  = 1;
  localparam int FCW  = $clog2(MAXF + 1);

  logic           clk = 1'b0;
  logic           reset;
  logic           safe_reset;
  logic [3:0]     safe_din;
  logic           safe_din_valid;
  logic           safe_unlocked;
  logic           locked_out;
  logic [FCW-1:0] fail_count;

  safe_seq_ctrl_if #(.NREQ(NREQ)) bus ();

  safe_seq_ctrl #(
    .NREQ          (NREQ),
    .LOCKOUT_CYCLES(LOCK),
    .HOLD_CYCLES   (HOLD),
    .MAX_FAILS     (MAXF)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .safe_reset    (safe_reset),
    .safe_din      (safe_din),
    .safe_din_valid(safe_din_valid),
    .safe_unlocked (safe_unlocked),
    .locked_out    (locked_out),
    .fail_count    (fail_count)
  );

  always #5 clk = ~clk;

  logic [15:0] sh_q  = '0;
  logic [2:0]  cnt_q = '0;

  always @(posedge clk) begin
    if (safe_reset) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (safe_din_valid) begin
      sh_q <= {sh_q[11:0], safe_din};
      if (cnt_q < 3'd4) cnt_q <= cnt_q + 3'd1;
    end
  end

  assign safe_unlocked = (cnt_q == 3'd4) &&
                         (sh_q == 16'hC0DE || sh_q == 16'hF00F);

  typedef struct {
    int   id;
    logic ok;
    int   cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   exp_fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_resp: got id=%0d ok=%b at cycle %0d, want none",
                 bus.resp_id, bus.resp_ok, cyc);
      end else begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.resp_id !== IDW'(e.id)) begin
          n_bad++;
          $display("FAIL resp_id: got %0d, want %0d", bus.resp_id, e.id);
        end
        n_cmp++;
        if (bus.resp_ok !== e.ok) begin
          n_bad++;
          $display("FAIL resp_ok: got %b, want %b", bus.resp_ok, e.ok);
        end
        n_cmp++;
        if (cyc != e.cyc) begin
          n_bad++;
          $display("FAIL resp_latency: got cycle %0d, want %0d", cyc, e.cyc);
        end
      end
    end
  end

  task automatic run_req(input int id, input logic [15:0] pin);
    bit       got;
    bit       pass;
    bit       dead;
    int       n;
    logic     want_rst;
    logic [3:0] nib;
    exp_t     t;
    pass = (pin == 16'hC0DE || pin == 16'hF00F);
    bus.req_pin[16*id +: 16] = pin;
    bus.req_valid[id] = 1'b1;
    got = 1'b0;
    for (int w = 0; w < 60 && !got; w++) begin
      #1;
      if (bus.req_ready[id] === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL grant_timeout: req %0d ready=%b, want grant", id,
               bus.req_ready);
      bus.req_valid = '0;
      return;
    end
    t.id  = id;
    t.ok  = pass;
    t.cyc = cyc + 6;
    exp_q.push_back(t);
    if (pass) exp_fails = 0;
    else if (exp_fails < MAXF) exp_fails++;
    dead = (exp_fails == MAXF);
    n = pass ? 7 + HOLD : (dead ? 7 : 6 + LOCK);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid = '1;
      #1;
      if (k == 1) begin
        n_cmp++;
        if (safe_reset !== 1'b1) begin
          n_bad++;
          $display("FAIL rstsafe: safe_reset=%b, want 1", safe_reset);
        end
      end
      if (k >= 2 && k <= 5) begin
        nib = 4'(pin >> (4 * (5 - k)));
        n_cmp++;
        if (safe_din_valid !== 1'b1 || safe_din !== nib) begin
          n_bad++;
          $display("FAIL nibble%0d: valid=%b din=%h, want 1/%h",
                   k - 2, safe_din_valid, safe_din, nib);
        end
      end
      n_cmp++;
      if (bus.req_ready !== '0) begin
        n_bad++;
        $display("FAIL busy_ready: step %0d ready=%b, want 0", k,
                 bus.req_ready);
      end
      if (k == 7) begin
        n_cmp++;
        if (fail_count !== FCW'(exp_fails) || locked_out !== dead) begin
          n_bad++;
          $display("FAIL fail_state: count=%0d lock=%b, want %0d/%b",
                   fail_count, locked_out, exp_fails, dead);
        end
      end
      if (k >= 7) begin
        want_rst = pass ? (k == n) : 1'b1;
        n_cmp++;
        if (safe_reset !== want_rst) begin
          n_bad++;
          $display("FAIL post_rst: step %0d safe_reset=%b, want %b",
                   k, safe_reset, want_rst);
        end
      end
      if (k == n) bus.req_valid = '0;
    end
    @(negedge clk);
    #1;
    if (!dead) begin
      n_cmp++;
      if (safe_reset !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_rst: safe_reset=%b, want 0", safe_reset);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL resp_missing: %0d pending, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_pin = {16'hC0DE, 16'hC0DE};
    bus.req_valid = '1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (safe_reset !== 1'b1 || bus.req_ready !== '0 ||
        bus.resp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out: srst=%b ready=%b rv=%b, want 1/00/0",
               safe_reset, bus.req_ready, bus.resp_valid);
    end
    n_cmp++;
    if (safe_din_valid !== 1'b0 || safe_din !== 4'h0 ||
        locked_out !== 1'b0 || fail_count !== '0) begin
      n_bad++;
      $display("FAIL reset_misc: dv=%b din=%h lock=%b fc=%0d, want zeros",
               safe_din_valid, safe_din, locked_out, fail_count);
    end
    bus.req_valid = '0;
    reset = 1'b0;
    exp_fails = 0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (safe_reset !== 1'b0 || fail_count !== '0) begin
      n_bad++;
      $display("FAIL post_reset_idle: srst=%b fc=%0d, want 0/0",
               safe_reset, fail_count);
    end
  endtask

  task automatic test_pass();
    run_req(0, 16'hC0DE);
  endtask

  task automatic test_alt();
    run_req(1, 16'hF00F);
  endtask

  task automatic test_fail();
    run_req(0, 16'h1234);
  endtask

  task automatic test_back_to_back();
    int   nxt;
    int   grants;
    exp_t t;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_fails = 0;
    bus.req_pin = {16'hF00F, 16'hC0DE};
    bus.req_valid = '1;
    nxt = 0;
    grants = 0;
    for (int w = 0; w < 200 && grants < 4; w++) begin
      #1;
      if (bus.req_ready !== '0) begin
        n_cmp++;
        if (bus.req_ready !== NREQ'(1 << nxt)) begin
          n_bad++;
          $display("FAIL rr_grant: got %b, want %b", bus.req_ready,
                   NREQ'(1 << nxt));
        end
        t.id  = nxt;
        t.ok  = 1'b1;
        t.cyc = cyc + 6;
        exp_q.push_back(t);
        grants++;
        nxt = (nxt + 1) % NREQ;
      end
      @(negedge clk);
    end
    bus.req_valid = '0;
    n_cmp++;
    if (grants != 4) begin
      n_bad++;
      $display("FAIL rr_timeout: got %0d grants, want 4", grants);
    end
    repeat (HOLD + 10) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL rr_resp: %0d pending, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    run_req(0, 16'h1234);
    bus.req_pin[31:16] = 16'h0000;
    bus.req_valid[1] = 1'b1;
    got = 1'b0;
    for (int w = 0; w < 60 && !got; w++) begin
      #1;
      if (bus.req_ready[1] === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL mid_grant: ready=%b, want 10", bus.req_ready);
    end
    repeat (4) @(negedge clk);
    #1;
    n_cmp++;
    if (safe_din_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_send2: dv=%b, want 1", safe_din_valid);
    end
    reset = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (safe_reset !== 1'b1 || bus.resp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_in_reset: srst=%b rv=%b, want 1/0",
               safe_reset, bus.resp_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_fails = 0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (fail_count !== '0 || safe_reset !== 1'b0 ||
        safe_din_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_abort: fc=%0d srst=%b dv=%b, want 0/0/0",
               fail_count, safe_reset, safe_din_valid);
    end
    repeat (12) @(negedge clk);
    run_req(1, 16'hC0DE);
  endtask

  task automatic test_dead();
    run_req(0, 16'h0000);
    run_req(1, 16'h0000);
    run_req(0, 16'h0000);
    bus.req_valid = '1;
    for (int w = 0; w < 40; w++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (bus.req_ready !== '0 || locked_out !== 1'b1 ||
          safe_reset !== 1'b1 || fail_count !== FCW'(MAXF)) begin
        n_bad++;
        $display("FAIL dead_hold: rdy=%b lock=%b srst=%b fc=%0d, want 00/1/1/%0d",
                 bus.req_ready, locked_out, safe_reset, fail_count, MAXF);
      end
    end
    bus.req_valid = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_fails = 0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (locked_out !== 1'b0 || fail_count !== '0) begin
      n_bad++;
      $display("FAIL dead_clear: lock=%b fc=%0d, want 0/0",
               locked_out, fail_count);
    end
    run_req(1, 16'hC0DE);
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_pin = '0;
    test_reset();
    test_pass();
    test_alt();
    test_fail();
    test_back_to_back();
    test_reset_mid();
    test_dead();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: run did not finish, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/safe_seq_ctrl.md
Name: safe_seq_ctrl

Overview:
Front-end controller for the 4-nibble PIN safe. It arbitrates round-robin between NREQ requesters, each presenting a 16-bit PIN. It resets the safe, streams the four nibbles into it MSB-first, samples the safe's unlocked flag and returns pass/fail. It also enforces a penalty delay after each failure, a permanent lockout after MAX_FAILS consecutive failures, and an automatic relock after a successful unlock.

Parameters:
NREQ, 2, number of requesters (>=2)
LOCKOUT_CYCLES, 16, penalty idle cycles after a failed attempt (>=1)
HOLD_CYCLES, 8, cycles the safe stays unlocked before forced relock (>=1)
MAX_FAILS, 3, consecutive failures that trigger permanent lockout (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester request; held until accepted
req_pin  in  16*NREQ  PIN of requester i at [16*i+15:16*i]
req_ready  out  NREQ  one-hot grant/accept; at most one bit high
resp_valid  out  1  one-cycle result pulse; no backpressure
resp_id  out  max(1,$clog2(NREQ))  requester index of the result
resp_ok  out  1  1 = safe unlocked
safe_reset  out  1  drives safe reset
safe_din  out  4  nibble to safe
safe_din_valid  out  1  nibble strobe
safe_unlocked  in  1  safe unlocked flag (combinational from safe state)
locked_out  out  1  permanent lockout indicator
fail_count  out  $clog2(MAX_FAILS+1)  consecutive failure count

Behaviour:
- While reset is high:
  - state=IDLE; fail_count=0, rr pointer=0, timers=0.
  - All outputs 0, except safe_reset, which equals 1 (safe_reset = reset | internal pulse).
- IDLE:
  - The arbiter grants the first requester with req_valid high, searching from (last_grant+1) mod NREQ. req_ready is driven combinationally for that one requester.
  - Accept happens on req_valid & req_ready (cycle T). Latch the PIN and id, update the rr pointer, go to RSTSAFE.
- RSTSAFE (T+1): safe_reset=1 for one cycle.
- SEND0..SEND3 (T+2..T+5):
  - safe_din_valid=1.
  - safe_din = pin[15:12], [11:8], [7:4], [3:0] in order.
- CHECK (T+6):
  - resp_valid=1, resp_id=latched id, resp_ok=safe_unlocked.
  - Request-to-result latency is exactly 6 cycles.
- Pass:
  - fail_count<=0, go to HOLD.
  - HOLD counts HOLD_CYCLES cycles, then RELOCK.
  - RELOCK asserts safe_reset for one cycle, then goes to IDLE.
- Fail:
  - fail_count<=fail_count+1.
  - If the new value equals MAX_FAILS, go to DEAD. Otherwise go to PENALTY.
  - PENALTY holds safe_reset=1 for LOCKOUT_CYCLES cycles, then goes to IDLE.
- DEAD:
  - locked_out=1, req_ready=0, safe_reset=1.
  - Left only by reset.
- Any valid path into UNLOCKED counts as a pass, including the alternate F00F sequence. The controller does not inspect PIN values.
- req_ready is 0 in every state except IDLE. Requests raised during busy states wait, and no request is dropped.
- Simultaneous req_valid from several requesters: only the rr winner is accepted. Others are served on subsequent IDLE visits in rotating order.
- Reset mid-sequence: abort immediately to IDLE. No response is emitted and fail_count is cleared.
- safe_din is 0 whenever safe_din_valid=0.
- Timer wrap-around: the counter is sized $clog2(max(LOCKOUT_CYCLES,HOLD_CYCLES)+1). It loads on state entry and exits on reaching 0; it never wraps.
- fail_count saturates at MAX_FAILS.

Decomposition:
- Package safe_pkg:
  - ctrl_state_t enum: IDLE, RSTSAFE, SEND0-3, CHECK, HOLD, RELOCK, PENALTY, DEAD.
  - Constants PIN_W=16, NIBBLE_W=4, NIBBLES=4.
- One sub-module, safe_rr_arbiter (NREQ):
  - Inputs: req vector, advance strobe.
  - Output: one-hot grant plus its encoded index.
  - Pointer update happens only on advance.

Test Plan:
- Req0 PIN C0DE at T → safe_din C,0,D,E on T+2..T+5; resp_valid at T+6 with id=0, ok=1. Relock pulse arrives HOLD_CYCLES+1 cycles after CHECK; fail_count=0.
- Req1 PIN F00F → ok=1 through the alternate sequence; id=1.
- Req0 PIN 1234 → ok=0, fail_count=1. safe_reset stays high for 16 cycles; req_ready stays 0 until IDLE.
- Three consecutive bad PINs (e.g. 0000) → third response ok=0, fail_count=3, locked_out=1. Further req_valid is never accepted until reset.
- Both req_valid high continuously with good PINs → grants alternate 0,1,0,1; resp_id follows the same order.
- Reset asserted at SEND2 → no resp_valid, safe_reset high during reset, state IDLE, fail_count=0. A following request completes normally.
